// File: rtl/fetch_unit.sv
// Front end of the 8-bit core: phase strobe generator, program counter,
// one-ahead prefetch and instruction register with jump/skip NOP injection.
module fetch_unit #(
  parameter int              PC_W         = 8,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter logic [7:0]      NOP_OP       = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            jump_req,
  input  logic [PC_W-1:0] jump_addr,
  input  logic            skip_req,
  input  logic [7:0]      prog_data,
  output logic [PC_W-1:0] prog_addr,
  output logic [PC_W-1:0] exec_pc,
  output logic [7:0]      inst_reg,
  output logic            inst_valid,
  output logic            q1,
  output logic            q2,
  output logic            q3,
  output logic            q4
);

  typedef enum logic [1:0] {
    PH_Q1 = 2'd0,
    PH_Q2 = 2'd1,
    PH_Q3 = 2'd2,
    PH_Q4 = 2'd3
  } phase_e;

  phase_e          phase_q, phase_d;
  logic [3:0]      stb_q, stb_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [7:0]      ir_q, ir_d;
  logic            iv_q, iv_d;
  logic            jp_q, jp_d;
  logic            sp_q, sp_d;

  always_comb begin
    phase_d = phase_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    tgt_d   = tgt_q;
    ir_d    = ir_q;
    iv_d    = iv_q;
    jp_d    = jp_q;
    sp_d    = sp_q;
    if (!hold) begin
      unique case (phase_q)
        PH_Q1: phase_d = PH_Q2;
        PH_Q2: phase_d = PH_Q3;
        PH_Q3: phase_d = PH_Q4;
        PH_Q4: phase_d = PH_Q1;
      endcase
      if (phase_q == PH_Q3) begin
        if (jump_req) begin
          jp_d  = 1'b1;
          tgt_d = jump_addr;
        end else if (skip_req) begin
          sp_d = 1'b1;
        end
      end
      // Flags are only set in Q3, so at most one is pending here.
      if (phase_q == PH_Q4) begin
        jp_d = 1'b0;
        sp_d = 1'b0;
        unique case (1'b1)
          jp_q: begin
            pc_d  = tgt_q;
            epc_d = tgt_q;
            ir_d  = NOP_OP;
            iv_d  = 1'b0;
          end
          sp_q: begin
            pc_d  = pc_q + PC_W'(1);
            epc_d = pc_q;
            ir_d  = NOP_OP;
            iv_d  = 1'b0;
          end
          default: begin
            pc_d  = pc_q + PC_W'(1);
            epc_d = pc_q;
            ir_d  = prog_data;
            iv_d  = 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    stb_d = 4'b0000;
    unique case (phase_d)
      PH_Q1: stb_d = 4'b0001;
      PH_Q2: stb_d = 4'b0010;
      PH_Q3: stb_d = 4'b0100;
      PH_Q4: stb_d = 4'b1000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_Q1;
      stb_q   <= 4'b0001;
      pc_q    <= RESET_VECTOR;
      epc_q   <= RESET_VECTOR;
      tgt_q   <= RESET_VECTOR;
      ir_q    <= NOP_OP;
      iv_q    <= 1'b0;
      jp_q    <= 1'b0;
      sp_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      stb_q   <= stb_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      tgt_q   <= tgt_d;
      ir_q    <= ir_d;
      iv_q    <= iv_d;
      jp_q    <= jp_d;
      sp_q    <= sp_d;
    end
  end

  assign prog_addr  = pc_q;
  assign exec_pc    = epc_q;
  assign inst_reg   = ir_q;
  assign inst_valid = iv_q;
  assign q1         = stb_q[0];
  assign q2         = stb_q[1];
  assign q3         = stb_q[2];
  assign q4         = stb_q[3];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: two instances (reset vector 00 and FE),
// expectations queued by stimulus, popped and compared by a negedge monitor.
module tb_fetch_unit;

  typedef struct packed {
    logic [7:0] ir;
    logic       v;
    logic [7:0] epc;
    logic [7:0] pa;
  } cyc_t;

  typedef struct packed {
    logic [3:0] st;
    logic [7:0] epc;
    logic [7:0] pa;
  } clk_t;

  logic       clk;
  logic       rst_a, rst_b, hold;
  logic       jump_req, skip_req;
  logic [7:0] jump_addr;
  logic [7:0] mem [256];

  logic [7:0] pa_a, epc_a, ir_a, pd_a;
  logic       iv_a, q1_a, q2_a, q3_a, q4_a;
  logic [7:0] pa_b, epc_b, ir_b, pd_b;
  logic       iv_b, q1_b, q2_b, q3_b, q4_b;

  logic       sel, mon_en;
  logic [7:0] m_pa, m_epc, m_ir;
  logic       m_iv;
  logic [3:0] m_st;

  cyc_t iq[$];
  clk_t pq[$];
  int   checks, failures;

  assign pd_a = mem[pa_a];
  assign pd_b = mem[pa_b];

  fetch_unit #(.PC_W(8), .RESET_VECTOR(8'h00), .NOP_OP(8'h00)) u_a (
    .clk(clk), .rst(rst_a), .hold(1'b0),
    .jump_req(jump_req), .jump_addr(jump_addr), .skip_req(skip_req),
    .prog_data(pd_a), .prog_addr(pa_a), .exec_pc(epc_a),
    .inst_reg(ir_a), .inst_valid(iv_a),
    .q1(q1_a), .q2(q2_a), .q3(q3_a), .q4(q4_a)
  );

  fetch_unit #(.PC_W(8), .RESET_VECTOR(8'hFE), .NOP_OP(8'h00)) u_b (
    .clk(clk), .rst(rst_b), .hold(hold),
    .jump_req(jump_req), .jump_addr(jump_addr), .skip_req(skip_req),
    .prog_data(pd_b), .prog_addr(pa_b), .exec_pc(epc_b),
    .inst_reg(ir_b), .inst_valid(iv_b),
    .q1(q1_b), .q2(q2_b), .q3(q3_b), .q4(q4_b)
  );

  always_comb begin
    if (sel) begin
      m_pa = pa_b; m_epc = epc_b; m_ir = ir_b; m_iv = iv_b;
      m_st = {q1_b, q2_b, q3_b, q4_b};
    end else begin
      m_pa = pa_a; m_epc = epc_a; m_ir = ir_a; m_iv = iv_a;
      m_st = {q1_a, q2_a, q3_a, q4_a};
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot(m_st)) begin
        failures++;
        $display("FAIL onehot: got strobes=%b want exactly one high", m_st);
      end
      if (pq.size() > 0) begin
        clk_t e;
        e = pq.pop_front();
        checks++;
        if (m_st !== e.st || m_epc !== e.epc || m_pa !== e.pa) begin
          failures++;
          $display("FAIL clk_state: got q=%b epc=%h pa=%h want q=%b epc=%h pa=%h",
                   m_st, m_epc, m_pa, e.st, e.epc, e.pa);
        end
      end
      if (m_st[3] && iq.size() > 0) begin
        cyc_t c;
        c = iq.pop_front();
        checks++;
        if (m_ir !== c.ir || m_iv !== c.v || m_epc !== c.epc || m_pa !== c.pa) begin
          failures++;
          $display("FAIL inst_cycle: got ir=%h v=%b epc=%h pa=%h want ir=%h v=%b epc=%h pa=%h",
                   m_ir, m_iv, m_epc, m_pa, c.ir, c.v, c.epc, c.pa);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pc_exp(input logic [7:0] ir, input logic v,
                        input logic [7:0] epc, input logic [7:0] pa);
    cyc_t c;
    c.ir = ir; c.v = v; c.epc = epc; c.pa = pa;
    iq.push_back(c);
  endtask

  task automatic pk_exp(input logic [3:0] st, input logic [7:0] epc,
                        input logic [7:0] pa);
    clk_t e;
    e.st = st; e.epc = epc; e.pa = pa;
    pq.push_back(e);
  endtask

  // One instruction cycle starting in Q1; bit p of a mask drives phase p.
  task automatic cycle(input logic [3:0] jm, input logic [3:0] sm,
                       input logic [7:0] ja);
    for (int p = 0; p < 4; p++) begin
      jump_req  = jm[p];
      skip_req  = sm[p];
      jump_addr = ja;
      tick(1);
    end
    jump_req = 1'b0;
    skip_req = 1'b0;
  endtask

  task automatic drained(input string name);
    @(negedge clk);
    #1;
    checks++;
    if (iq.size() != 0 || pq.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got pending=%0d/%0d want 0/0",
               name, iq.size(), pq.size());
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    mem[8'h00] = 8'h1C; mem[8'h01] = 8'hC5;
    mem[8'h02] = 8'h0A; mem[8'h03] = 8'h64;
    mem[8'h40] = 8'hA5; mem[8'h41] = 8'h3C;
    mem[8'h42] = 8'h77; mem[8'h43] = 8'hE1;
    mem[8'h10] = 8'h5A; mem[8'h11] = 8'h96;
    mem[8'h12] = 8'h2D; mem[8'hFE] = 8'hB4;
    mem[8'hFF] = 8'h4B;
    rst_a = 1'b1; rst_b = 1'b1; hold = 1'b0;
    jump_req = 1'b0; skip_req = 1'b0; jump_addr = 8'h00;
    sel = 1'b0; mon_en = 1'b0;
    tick(3);

    rst_a = 1'b0;
    pk_exp(4'b1000, 8'h00, 8'h00);
    pk_exp(4'b0100, 8'h00, 8'h00);
    pk_exp(4'b0010, 8'h00, 8'h00);
    pk_exp(4'b0001, 8'h00, 8'h00);
    pk_exp(4'b1000, 8'h00, 8'h01);
    pc_exp(8'h00, 1'b0, 8'h00, 8'h00);
    pc_exp(8'h1C, 1'b1, 8'h00, 8'h01);
    pc_exp(8'hC5, 1'b1, 8'h01, 8'h02);
    pc_exp(8'h0A, 1'b1, 8'h02, 8'h03);
    pc_exp(8'h00, 1'b0, 8'h40, 8'h40);
    pc_exp(8'hA5, 1'b1, 8'h40, 8'h41);
    pc_exp(8'h3C, 1'b1, 8'h41, 8'h42);
    pc_exp(8'h00, 1'b0, 8'h42, 8'h43);
    pc_exp(8'hE1, 1'b1, 8'h43, 8'h44);
    pc_exp(8'h00, 1'b0, 8'h10, 8'h10);
    pc_exp(8'h5A, 1'b1, 8'h10, 8'h11);
    pc_exp(8'h96, 1'b1, 8'h11, 8'h12);
    pc_exp(8'h2D, 1'b1, 8'h12, 8'h13);
    pc_exp(8'h00, 1'b0, 8'h00, 8'h00);
    pc_exp(8'h1C, 1'b1, 8'h00, 8'h01);
    pc_exp(8'hC5, 1'b1, 8'h01, 8'h02);
    mon_en = 1'b1;

    cycle(4'b0000, 4'b0000, 8'h00);
    cycle(4'b0000, 4'b0000, 8'h00);
    cycle(4'b0000, 4'b0000, 8'h00);
    cycle(4'b0100, 4'b0000, 8'h40);
    cycle(4'b0000, 4'b0000, 8'h00);
    cycle(4'b0000, 4'b0000, 8'h00);
    cycle(4'b0000, 4'b0100, 8'h00);
    cycle(4'b0000, 4'b0000, 8'h00);
    cycle(4'b0100, 4'b0100, 8'h10);
    cycle(4'b0000, 4'b0000, 8'h00);
    cycle(4'b1011, 4'b0001, 8'h80);
    cycle(4'b0000, 4'b0000, 8'h00);

    // Jump captured at Q3, then reset lands on the Q4 edge.
    tick(2);
    jump_req = 1'b1; jump_addr = 8'h80;
    tick(1);
    jump_req = 1'b0; rst_a = 1'b1;
    tick(1);
    rst_a = 1'b0;
    cycle(4'b0000, 4'b0000, 8'h00);
    cycle(4'b0000, 4'b0000, 8'h00);
    drained("seq_jump_skip_reset");

    mon_en = 1'b0;
    tick(1);
    sel = 1'b1; rst_a = 1'b1; rst_b = 1'b0;
    pc_exp(8'h00, 1'b0, 8'hFE, 8'hFE);
    pc_exp(8'hB4, 1'b1, 8'hFE, 8'hFF);
    pc_exp(8'h4B, 1'b1, 8'hFF, 8'h00);
    pc_exp(8'h1C, 1'b1, 8'h00, 8'h01);
    pc_exp(8'hC5, 1'b1, 8'h01, 8'h02);
    mon_en = 1'b1;
    cycle(4'b0000, 4'b0000, 8'h00);
    cycle(4'b0000, 4'b0000, 8'h00);

    pk_exp(4'b1000, 8'hFF, 8'h00);
    for (int i = 0; i < 6; i++) pk_exp(4'b0100, 8'hFF, 8'h00);
    pk_exp(4'b0010, 8'hFF, 8'h00);
    pk_exp(4'b0001, 8'hFF, 8'h00);
    pk_exp(4'b1000, 8'h00, 8'h01);
    tick(1);
    hold = 1'b1;
    tick(5);
    hold = 1'b0;
    tick(3);
    cycle(4'b0000, 4'b0000, 8'h00);
    drained("wrap_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Front end of the 8-bit core. It generates the four one-hot instruction-cycle phase strobes (q1..q4) that drive the decoder's clk1..clk4 inputs. It also owns the program counter, fetches from program memory, and holds the instruction register that feeds the decoder's inst_reg. Fetch is pipelined one instruction ahead, and the unit handles jump and skip flushes by injecting NOP (8'h00).

Parameters:
PC_W, 8, program counter / program memory address width
RESET_VECTOR, 0, PC value loaded on reset (PC_W bits)
NOP_OP, 8'h00, opcode injected on reset and flush

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
hold  input  1  freeze request: phase, PC, IR and pending flags hold while 1
jump_req  input  1  branch request, sampled only in Q3
jump_addr  input  PC_W  branch target, sampled with jump_req
skip_req  input  1  skip-next-instruction request, sampled only in Q3
prog_data  input  8  program memory read data (combinational read of prog_addr)
prog_addr  output  PC_W  program memory address (= pc register)
exec_pc  output  PC_W  address of the instruction currently in inst_reg
inst_reg  output  8  instruction register to decoder
inst_valid  output  1  1 = inst_reg holds a fetched instruction; 0 = injected NOP
q1,q2,q3,q4  output  1 each  one-hot phase strobes, registered

Behaviour:
- Phase counter: 2 bits, Q1->Q2->Q3->Q4->Q1, one step per clk while hold=0; q1..q4 are its registered one-hot decode. Exactly one strobe is high in every cycle after reset.
- Reset (rst=1 at edge, any phase, overrides all):
  - phase=Q1 (q1=1, others 0), pc=RESET_VECTOR, exec_pc=RESET_VECTOR.
  - inst_reg=NOP_OP, inst_valid=0; jump/skip pending flags cleared.
- Instruction cycle = 4 clocks. prog_addr=pc is stable for the whole cycle; prog_data is sampled only at the Q4 edge.
- Q3 edge (hold=0):
  - If jump_req=1: jump_pend<=1 and jmp_tgt<=jump_addr.
  - Else if skip_req=1: skip_pend<=1.
  - Requests in Q1, Q2 or Q4 are ignored.
- Q4 edge (hold=0), checked in priority order:
  1. jump_pend: pc<=jmp_tgt, exec_pc<=jmp_tgt, inst_reg<=NOP_OP, inst_valid<=0. The prefetched word is discarded.
  2. skip_pend: pc<=pc+1, exec_pc<=pc, inst_reg<=NOP_OP, inst_valid<=0.
  3. Normal: inst_reg<=prog_data, inst_valid<=1, exec_pc<=pc, pc<=pc+1.
  - In every case both pending flags clear at this edge.
- Jump and skip in the same Q3: jump wins, skip is dropped.
- Latency:
  - An instruction at address A is fetched during the cycle that executes A-1, and sits in inst_reg for the whole following cycle.
  - After reset, the first cycle executes NOP. mem[RESET_VECTOR] appears in inst_reg after the 4th clk.
  - A jump requested in cycle N causes NOP in cycle N+1 and the target instruction in cycle N+2.
- PC arithmetic is modulo 2^PC_W: pc = all-ones increments to 0, no flag.
- hold=1: no register changes (phase, pc, exec_pc, inst_reg, inst_valid, pending flags); strobes stay on the current phase. A hold asserted in Q3 defers sampling of jump_req/skip_req to the first non-held Q3 edge.
- No combinational path from inputs to outputs other than via registers.

Test Plan:
- Reset/sequential fetch: PC_W=8, RESET_VECTOR=0, mem[0..3]=8'h1C,8'hC5,8'h0A,8'h64; release rst -> q1..q4 cycle 1000,0100,0010,0001. inst_reg=00/inst_valid=0 for the first 4 clks, then 1C(exec_pc 0), C5(1), 0A(2), 64(3). prog_addr steps 0,1,2,3,4 on each Q4 edge.
- Jump: jump_req=1, jump_addr=8'h40 during Q3 of the cycle executing address 2 -> next cycle inst_reg=00, inst_valid=0, exec_pc=40, prog_addr=40. The following cycle inst_reg=mem[40h], prog_addr=41.
- Skip: skip_req=1 in Q3 while executing address 5 -> next cycle inst_reg=00 (address 6 discarded), exec_pc=6. The following cycle inst_reg=mem[7], exec_pc=7.
- Jump+skip same Q3, jump_addr=8'h10 -> jump taken (exec_pc 10), no extra skip. Also: jump_req pulsed in Q1/Q2/Q4 only -> ignored, sequential flow unchanged.
- Wrap/hold: RESET_VECTOR=8'hFE -> exec_pc FE,FF,00,01. hold=1 for 5 clks during Q2 -> q2 stays high, all outputs frozen, then the sequence resumes with Q3.
- Mid-operation reset: rst=1 at Q3 with jump pending -> next cycle q1=1, pc=RESET_VECTOR, inst_reg=00, and the pending jump is never taken.
